// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice with a registered carry,
// LSB first, WIDTH cycles per operation plus one cycle to present the result.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   busy_d, done_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-2:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  logic             start_ok_c;
  logic             last_c;
  logic             bit_s_c;
  logic             bit_c_c;
  logic [WIDTH-1:0] res_nx_c;

  // Full-adder slice on the current LSBs; the MSB cycle closes the operation.
  assign start_ok_c = start && (state_q != S_RUN);
  assign last_c     = (state_q == S_RUN) && (cnt_q == LAST_BIT);
  assign bit_s_c    = a_q[0] ^ b_q[0] ^ carry_q;
  assign bit_c_c    = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign res_nx_c   = {bit_s_c, res_q};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured outside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN:  if (last_c) state_d = S_DONE;
      S_DONE: state_d = start ? S_RUN : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake flags decoded from the upcoming state so they register in step with it.
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == S_RUN)  busy_d = 1'b1;
    if (state_d == S_DONE) done_d = 1'b1;
  end

  // Handshake output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
    end
  end

  // Operand shifters, serial carry, bit counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (start_ok_c) begin
      // Subtraction as A + ~B + 1: the +1 rides in on the initial carry.
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      res_q   <= res_nx_c[WIDTH-1:1];
      carry_q <= bit_c_c;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_c) begin
        // carry_q still holds the carry into the MSB on this cycle.
        sum       <= res_nx_c;
        carry_out <= bit_c_c;
        overflow  <= carry_q ^ bit_c_c;
      end
    end
  end

endmodule
